demux_1_4: RTL and testbench

Stream demultiplexer, the distributing counterpart of the 4-to-1 multiplexer. It accepts one DW-bit input stream tagged with a 2-bit channel select. Each beat is routed into one of four output channels. Every channel has its own 2-entry FIFO and valid/ready handshake, so a stalled channel blocks only traffic addressed to it. Per-channel delivered-beat counters are exposed for debug.

---
 rtl/demux_1_4.sv | 69 ++++++
 tb/tb_demux_1_4.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_4.sv
// 1-to-4 stream demultiplexer: each input beat is steered by in_sel into one of
// four independent 2-entry FIFOs, each with its own handshake and delivered-beat counter.
module demux_1_4 #(
    parameter int DW = 2,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      in_sel,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data,
    output logic [4*CW-1:0] ch_cnt
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both
    // high; valid never depends on ready, and in_ready never depends on out_ready.
    logic [3:0] full;

    assign in_ready = rst_n && !full[in_sel];

    for (genvar n = 0; n < 4; n++) begin : g_ch
        logic [DW-1:0] mem [2];
        logic          wr_ptr;
        logic          rd_ptr;
        logic [1:0]    count;
        logic [CW-1:0] cnt;
        logic          push;
        logic          pop;

        assign push = in_valid && in_ready && (in_sel == 2'(n));
        assign pop  = (count != 2'd0) && out_ready[n];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                mem[0] <= '0;
                mem[1] <= '0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                    cnt    <= cnt + CW'(1);
                end
                // Push needs count<2 and pop needs count>0, so both together leave count unchanged.
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end

        assign full[n]              = (count == 2'd2);
        assign out_valid[n]         = (count != 2'd0);
        assign out_data[n*DW +: DW] = mem[rd_ptr];
        assign ch_cnt[n*CW +: CW]   = cnt;
    end

endmodule

// File: tb/tb_demux_1_4.sv
// Directed bench for demux_1_4: reset, routing, backpressure, push/pop overlap,
// counter wrap and mid-stream reset, each checked against hand-computed values.
module tb_demux_1_4;

    localparam int DW = 2;
    localparam int CW = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*DW-1:0] out_data;
    logic [4*CW-1:0] ch_cnt;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    demux_1_4 #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ch_cnt    (ch_cnt)
    );

    // Clock and initial input levels
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 2'd0;
        out_ready = 4'b0000;
    end

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 4'b0000;
        drive(1'b1, 2'd2, 2'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 4'b0000 || in_ready !== 1'b0 || ch_cnt !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: out_valid=%b in_ready=%b ch_cnt=%h, want 0000/0/0",
                         i, out_valid, in_ready, ch_cnt);
            end
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: out_data=%h, want 0", out_data);
        end
        rst_n = 1'b1;
        drive(1'b0, 2'd2, 2'b11);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0000", in_ready, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: out_valid=%b, want 0000", out_valid);
        end
    endtask

    task automatic test_routing();
        logic [1:0]    sel_v [4];
        logic [DW-1:0] dat_v [4];
        sel_v = '{2'd0, 2'd1, 2'd2, 2'd3};
        dat_v = '{2'b01, 2'b10, 2'b11, 2'b00};
        out_ready = 4'b1111;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(1'b1, sel_v[i], dat_v[i]);
            else       drive(1'b0, 2'd0, 2'b00);
            if (i < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL route_ready beat%0d: in_ready=%b, want 1", i, in_ready);
                end
            end
            checks++;
            if (i == 0) begin
                if (out_valid !== 4'b0000) begin
                    errors++;
                    $display("FAIL route_valid cyc0: out_valid=%b, want 0000", out_valid);
                end
            end else begin
                if (out_valid !== (4'b0001 << (i - 1)) || out_data[(i-1)*DW +: DW] !== dat_v[i-1]) begin
                    errors++;
                    $display("FAIL route_out cyc%0d: out_valid=%b data=%b, want %b/%b", i, out_valid,
                             out_data[(i-1)*DW +: DW], 4'b0001 << (i - 1), dat_v[i-1]);
                end
            end
            tick();
        end
        checks++;
        if (out_valid !== 4'b0000 || ch_cnt !== {8'd1, 8'd1, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL route_end: out_valid=%b ch_cnt=%h, want 0000/01010101", out_valid, ch_cnt);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 2'b01);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: in_ready=%b, want 1", in_ready);
        end
        tick();
        drive(1'b1, 2'd1, 2'b10);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: in_ready=%b, want 1", in_ready);
        end
        tick();
        drive(1'b1, 2'd1, 2'b11);
        checks++;
        if (in_ready !== 1'b0 || out_valid[1] !== 1'b1 || out_data[DW +: DW] !== 2'b01) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b valid1=%b head=%b, want 0/1/01",
                     in_ready, out_valid[1], out_data[DW +: DW]);
        end
        drive(1'b0, 2'd0, 2'b11);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_sel: in_ready=%b, want 1", in_ready);
        end
        tick();
        // Channel 1 pops this cycle, but a full FIFO still refuses the third beat.
        out_ready = 4'b1111;
        drive(1'b1, 2'd1, 2'b11);
        checks++;
        if (in_ready !== 1'b0 || out_data[DW +: DW] !== 2'b01) begin
            errors++;
            $display("FAIL bp_pop_full: in_ready=%b head=%b, want 0/01", in_ready, out_data[DW +: DW]);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid[1] !== 1'b1 || out_data[DW +: DW] !== 2'b10) begin
            errors++;
            $display("FAIL bp_drain1: in_ready=%b valid1=%b head=%b, want 1/1/10",
                     in_ready, out_valid[1], out_data[DW +: DW]);
        end
        tick();
        drive(1'b0, 2'd0, 2'b00);
        checks++;
        if (out_valid[1] !== 1'b1 || out_data[DW +: DW] !== 2'b11) begin
            errors++;
            $display("FAIL bp_third: valid1=%b head=%b, want 1/11", out_valid[1], out_data[DW +: DW]);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000 || ch_cnt[CW +: CW] !== 8'd4 || ch_cnt[0 +: CW] !== 8'd1) begin
            errors++;
            $display("FAIL bp_end: out_valid=%b cnt1=%0d cnt0=%0d, want 0000/4/1",
                     out_valid, ch_cnt[CW +: CW], ch_cnt[0 +: CW]);
        end
    endtask

    task automatic test_push_pop();
        out_ready = 4'b0000;
        drive(1'b1, 2'd3, 2'b10);
        tick();
        out_ready = 4'b1000;
        drive(1'b1, 2'd3, 2'b01);
        checks++;
        if (in_ready !== 1'b1 || out_valid[3] !== 1'b1 || out_data[3*DW +: DW] !== 2'b10) begin
            errors++;
            $display("FAIL pp_before: in_ready=%b valid3=%b head=%b, want 1/1/10",
                     in_ready, out_valid[3], out_data[3*DW +: DW]);
        end
        tick();
        out_ready = 4'b0000;
        drive(1'b0, 2'd3, 2'b00);
        checks++;
        if (in_ready !== 1'b1 || out_valid[3] !== 1'b1 || out_data[3*DW +: DW] !== 2'b01
            || ch_cnt[3*CW +: CW] !== 8'd2) begin
            errors++;
            $display("FAIL pp_after: in_ready=%b valid3=%b head=%b cnt3=%0d, want 1/1/01/2",
                     in_ready, out_valid[3], out_data[3*DW +: DW], ch_cnt[3*CW +: CW]);
        end
        out_ready = 4'b1000;
        tick();
        checks++;
        if (out_valid !== 4'b0000 || ch_cnt[3*CW +: CW] !== 8'd3) begin
            errors++;
            $display("FAIL pp_drain: out_valid=%b cnt3=%0d, want 0000/3", out_valid, ch_cnt[3*CW +: CW]);
        end
    endtask

    // Channel 0 has delivered 1 beat so far; 255 more bring its total to 256, wrapping to 0.
    task automatic test_counter_wrap();
        logic [DW-1:0] exp_d;
        exp_q.delete();
        out_ready = 4'b0001;
        for (int i = 0; i <= 255; i++) begin
            if (i < 255) drive(1'b1, 2'd0, DW'(i));
            else         drive(1'b0, 2'd0, 2'b00);
            if (i < 255) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_ready beat%0d: in_ready=%b, want 1", i, in_ready);
                end
            end
            if (i == 255) begin
                checks++;
                if (ch_cnt[0 +: CW] !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_pre: cnt0=%0d, want 255", ch_cnt[0 +: CW]);
                end
            end
            if (out_valid[0] === 1'b1) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (out_data[0 +: DW] !== exp_d) begin
                    errors++;
                    $display("FAIL wrap_data cyc%0d: data=%b, want %b", i, out_data[0 +: DW], exp_d);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            tick();
        end
        checks++;
        if (out_valid !== 4'b0000 || exp_q.size() != 0 || ch_cnt !== {8'd3, 8'd1, 8'd4, 8'd0}) begin
            errors++;
            $display("FAIL wrap_end: out_valid=%b left=%0d ch_cnt=%h, want 0000/0/03010400",
                     out_valid, exp_q.size(), ch_cnt);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 4'b0000;
        drive(1'b1, 2'd2, 2'b10);
        tick();
        drive(1'b1, 2'd2, 2'b01);
        tick();
        drive(1'b0, 2'd2, 2'b00);
        checks++;
        if (out_valid !== 4'b0100 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: out_valid=%b in_ready=%b, want 0100/0", out_valid, in_ready);
        end
        // Handshakes presented during the reset edge must be discarded.
        rst_n     = 1'b0;
        out_ready = 4'b1111;
        drive(1'b1, 2'd0, 2'b11);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 2'b00);
        checks++;
        if (out_valid !== 4'b0000 || ch_cnt !== '0 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b ch_cnt=%h out_data=%h in_ready=%b, want 0000/0/0/1",
                     out_valid, ch_cnt, out_data, in_ready);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_routing();
        test_backpressure();
        test_push_pop();
        test_counter_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
